// File: rtl/prio_arb_pkg.sv
// Shared types, mode encodings and sizing helper for prio_arbiter and its encoder.
package prio_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder: one-hot, binary index and valid,
// selecting either the lowest or the highest set bit.
module prio_enc_n
    import prio_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = clog2_min1(N),
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [N-1:0] i_vec,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_vld
);

    // Ascending scan: the last hit wins for highest-first, the first hit sticks for lowest-first.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_vec[i] && !(LOW_FIRST && o_vld)) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = W'(i);
                o_vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter, fixed-priority or round-robin, one-hot grant plus index.
// PRIO_ARB_LOCK_EN: grant is held until ack or abandon; undefined re-arbitrates every cycle.
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_vld
);

    state_t         r_state,   w_state_nxt;
    logic [N-1:0]   r_gnt,     w_gnt_nxt;
    logic [W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
    logic           r_gnt_vld, w_gnt_vld_nxt;
    logic [W-1:0]   r_ptr,     w_ptr_nxt;

    logic [W-1:0]   w_ptr_inc;
    logic [W-1:0]   w_ptr_eff;
    logic           w_arb;
    logic [N-1:0]   w_mask;
    logic [N-1:0]   w_req_masked;

    logic [N-1:0]   w_m_oh,  w_u_oh,  w_f_oh,  w_win_oh;
    logic [W-1:0]   w_m_idx, w_u_idx, w_f_idx, w_win_idx;
    logic           w_m_vld, w_u_vld, w_f_vld, w_win_vld;

    assign w_ptr_inc = (r_gnt_idx == W'(N - 1)) ? '0 : r_gnt_idx + W'(1);

`ifdef PRIO_ARB_LOCK_EN
    logic w_release;

    assign w_release = (r_state == BUSY) && (ack || !req[r_gnt_idx]);
    assign w_arb     = (r_state == IDLE) || w_release;
    // Releasing cycle arbitrates with the already-advanced pointer.
    assign w_ptr_eff = w_release ? w_ptr_inc : r_ptr;
`else
    logic w_unused_ack;

    assign w_unused_ack = ack;
    assign w_arb        = 1'b1;
    assign w_ptr_eff    = (r_state == BUSY) ? w_ptr_inc : r_ptr;
`endif

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_mask[i] = (i >= 32'(w_ptr_eff));
        end
    end

    assign w_req_masked = req & w_mask;

    prio_enc_n #(.N(N), .W(W), .LOW_FIRST(1'b1)) u_enc_rr_masked (
        .i_vec    (w_req_masked),
        .o_onehot (w_m_oh),
        .o_idx    (w_m_idx),
        .o_vld    (w_m_vld)
    );

    prio_enc_n #(.N(N), .W(W), .LOW_FIRST(1'b1)) u_enc_rr_wrap (
        .i_vec    (req),
        .o_onehot (w_u_oh),
        .o_idx    (w_u_idx),
        .o_vld    (w_u_vld)
    );

    prio_enc_n #(.N(N), .W(W), .LOW_FIRST(1'b0)) u_enc_fixed (
        .i_vec    (req),
        .o_onehot (w_f_oh),
        .o_idx    (w_f_idx),
        .o_vld    (w_f_vld)
    );

    always_comb begin
        w_win_oh  = w_f_oh;
        w_win_idx = w_f_idx;
        w_win_vld = w_f_vld;
        if (mode == MODE_RR) begin
            if (w_m_vld) begin
                w_win_oh  = w_m_oh;
                w_win_idx = w_m_idx;
                w_win_vld = w_m_vld;
            end else begin
                w_win_oh  = w_u_oh;
                w_win_idx = w_u_idx;
                w_win_vld = w_u_vld;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_gnt_vld_nxt = r_gnt_vld;
        w_ptr_nxt     = w_ptr_eff;
        if (w_arb) begin
            w_gnt_nxt     = w_win_oh;
            w_gnt_idx_nxt = w_win_vld ? w_win_idx : '0;
            w_gnt_vld_nxt = w_win_vld;
            w_state_nxt   = w_win_vld ? BUSY : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_ptr     <= w_ptr_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised, registered N-way priority arbiter; next generation of the team's 4-input combinational priority encoder. Selects one requester per arbitration, in fixed-priority or round-robin mode. Outputs a one-hot grant and its binary index, and holds the grant until the winner acknowledges it. Sits between multiple request sources and a shared resource, such as a bus port or a memory bank.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `W`, default `$clog2(N)`: width of the grant index. Derived; do not override.

- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, N: request vector; bit i = requester i.
- `mode`, input, 1: 0 = fixed priority (highest index wins); 1 = round-robin.
- `ack`, input, 1: current grant holder releases the resource.
- `gnt`, output, N: one-hot grant, registered.
- `gnt_idx`, output, W: binary index of the granted requester, registered.
- `gnt_vld`, output, 1: a grant is active, registered.

## Operation
- **States:**
  - IDLE: no grant held.
  - BUSY: grant held.
- **Reset values:**
  - State = IDLE; `gnt`=0, `gnt_idx`=0, `gnt_vld`=0.
  - Round-robin pointer `ptr`=0.
- **Fixed-priority mode (`mode`=0):** the highest set bit of `req` wins. This is the 4-input encoder behaviour generalised to N.
- **Round-robin mode (`mode`=1):**
  - The lowest set bit at index ≥ `ptr` wins.
  - If there is none, search wraps to index 0 upward.
- **IDLE → BUSY:** when `req` ≠ 0, the winner is registered into `gnt`/`gnt_idx`, and `gnt_vld`=1.
- **BUSY, hold:** the grant holds while `req[gnt_idx]`=1 and `ack`=0; `req` changes on other bits are ignored.
- **BUSY, release:** release occurs on `ack`=1, or when `req[gnt_idx]` drops (abandon).
  - On release, `ptr` ← (`gnt_idx`+1) mod N. Wrap: `gnt_idx`=N-1 sets `ptr`=0.
  - The release cycle also re-arbitrates over the current `req` with the updated priority, giving back-to-back grants with no idle bubble.
  - The current-cycle requester set includes the releasing requester. In round-robin it is now lowest priority; in fixed mode it may win again.
  - If there are no other requests, the FSM returns to IDLE and `gnt`=0, `gnt_vld`=0 on the next cycle.
- **`ack` in IDLE:** ignored.
- **`mode` change while BUSY:** no effect on the held grant; applies at the next arbitration.
- **`rst` mid-grant:** the grant drops the next cycle and `ptr` returns to 0.
- **Output invariant:** `gnt` is always zero or one-hot, and `gnt_idx` matches it. When `gnt_vld`=0, `gnt_idx`=0.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge k gives a grant visible after edge k.
- Release to next grant: 1 cycle. `ack` at edge k gives the new `gnt` after edge k.
- Arbitration logic is combinational from `req`/`ptr`/`mode` into the output registers; there is no path from input to output.
- Every grant holder owns the resource for at least 1 cycle.

## Configuration
- `PRIO_ARB_LOCK_EN` defined (default build): BUSY-hold behaviour as above; `ack` is functional.
- `PRIO_ARB_LOCK_EN` undefined:
  - No hold. The FSM collapses to re-arbitration every cycle.
  - `ack` is ignored.
  - `ptr` advances past each winner every cycle that `gnt_vld`=1.
  - Output registers and the 1-cycle latency are unchanged.

## Structure
- **Shared package `prio_arb_pkg`:**
  - State enum: IDLE, BUSY.
  - Mode constants: `MODE_FIXED`=0, `MODE_RR`=1.
  - A function returning `$clog2` with a minimum of 1.
- **Sub-module `prio_enc_n`:** combinational N-input priority encoder.
  - Ports: N-bit input, one-hot out, W-bit index out, valid out; selectable lowest/highest-first.
  - Instantiated twice for round-robin: once on the masked vector (`req` & bits ≥ `ptr`), once on the unmasked vector. The masked result is used if it is valid.
  - Fixed mode uses the highest-first instance.

## Test plan
All scenarios use N=4.
- **Reset:** `rst`=1 with `req`=4'b1111 → `gnt`=0, `gnt_vld`=0, `gnt_idx`=0. After `rst` drops, a grant appears 1 cycle later.
- **Fixed priority:** `mode`=0, `req`=4'b0110 → `gnt`=4'b0100, `gnt_idx`=2. Then `ack`=1 with `req` unchanged → `gnt`=4'b0100 again.
- **Round-robin rotation:** `mode`=1, `req`=4'b1111 held, `ack` pulsed each cycle → `gnt_idx` sequence 0,1,2,3,0.
- **Wrap and hold:** `mode`=1, `ptr`=3, `req`=4'b0011 → `gnt_idx`=0. With `ack`=0 for 5 cycles while `req`=4'b0111, the grant is stable at 0.
- **Abandon:** while granted idx 1, `req` goes 4'b0010→4'b1000 with `ack`=0 → next cycle `gnt`=4'b1000, `ptr`=2.
- **Lock disabled:** build without `PRIO_ARB_LOCK_EN`, `mode`=1, `req`=4'b0101, `ack`=0 → `gnt_idx` alternates 0,2,0,2 every cycle.
